// File: rtl/clock_divider_pkg.sv
// Shared types and constants for the runtime-programmable clock divider.
package clock_divider_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Smallest divisor that still gives both a high and a low phase.
   localparam int MIN_DIVISOR = 2;

   // Divisor/counter width used when a block does not override it.
   localparam int DEFAULT_WIDTH = 16;

   typedef logic [DEFAULT_WIDTH-1:0] divisor_t;

endpackage

// File: rtl/clock_divider_counter.sv
// Period counter for the clock divider: position within the current period,
// end-of-period detect and the level the output should take on the next cycle.
module clock_divider_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             restart,
   input  logic             advance,
   input  logic [WIDTH-1:0] divisor,
   output logic             period_end,
   output logic             high_next
);

   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] count_inc;
   logic [WIDTH-1:0] half;

   assign count_inc  = count + WIDTH'(1);
   assign half       = divisor >> 1;
   assign period_end = (count == (divisor - WIDTH'(1)));
   assign high_next  = (count_inc < half);

   // Counter restarts at each period boundary and otherwise steps once per cycle.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (restart) begin
         count <= '0;
      end else if (advance) begin
         count <= count_inc;
      end
   end

endmodule

// File: rtl/clock_divider_controller.sv
// Clock divider controller: start/stop sequencing, divisor handshake and a
// pending register so that new divisors and stops only land on period edges.
module clock_divider_controller
   import clock_divider_pkg::*;
#(
   parameter int WIDTH           = 16,
   parameter int DEFAULT_DIVISOR = 2
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [WIDTH-1:0] cfg_divisor,
   output logic             cfg_error,
   output logic             clock_divided,
   output logic             period_start,
   output logic             running,
   output logic [WIDTH-1:0] active_divisor,
   output logic             pending
);

   localparam logic [WIDTH-1:0] RESET_DIVISOR = WIDTH'(DEFAULT_DIVISOR);
   localparam logic [WIDTH-1:0] MIN_DIV       = WIDTH'(MIN_DIVISOR);

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] pending_divisor;
   logic [WIDTH-1:0] pending_divisor_next;
   logic [WIDTH-1:0] active_next;
   logic             pending_next;
   logic             clock_next;
   logic             start_next;
   logic             transfer;
   logic             accept;
   logic             reject;
   logic             restart;
   logic             advance;
   logic             period_end;
   logic             high_next;

   assign cfg_ready = !pending;
   assign running   = (state == RUN);
   assign transfer  = cfg_valid && cfg_ready;
   assign accept    = transfer && (cfg_divisor >= MIN_DIV);
   assign reject    = transfer && (cfg_divisor < MIN_DIV);

   clock_divider_counter #(
      .WIDTH(WIDTH)
   ) u_counter (
      .clock      (clock),
      .reset_n    (reset_n),
      .restart    (restart),
      .advance    (advance),
      .divisor    (active_divisor),
      .period_end (period_end),
      .high_next  (high_next)
   );

   // Next-state logic: in IDLE divisors load directly; in RUN they wait in the
   // pending register and, like stop requests, only act at the period end.
   always_comb begin
      state_next           = state;
      clock_next           = clock_divided;
      start_next           = 1'b0;
      active_next          = active_divisor;
      pending_next         = pending;
      pending_divisor_next = pending_divisor;
      restart              = 1'b0;
      advance              = 1'b0;

      case (state)
         IDLE: begin
            if (accept) begin
               active_next = cfg_divisor;
            end
            if (enable) begin
               restart    = 1'b1;
               clock_next = 1'b1;
               start_next = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            if (period_end) begin
               restart = 1'b1;
               if (pending) begin
                  active_next  = pending_divisor;
                  pending_next = 1'b0;
               end
               if (enable) begin
                  clock_next = 1'b1;
                  start_next = 1'b1;
               end else begin
                  clock_next = 1'b0;
                  state_next = IDLE;
               end
            end else begin
               advance    = 1'b1;
               clock_next = high_next;
            end
            if (accept) begin
               pending_next         = 1'b1;
               pending_divisor_next = cfg_divisor;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State and output registers; reset drops the output immediately and
   // discards any divisor still waiting for a period end.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state           <= IDLE;
         clock_divided   <= 1'b0;
         period_start    <= 1'b0;
         cfg_error       <= 1'b0;
         pending         <= 1'b0;
         pending_divisor <= '0;
         active_divisor  <= RESET_DIVISOR;
      end else begin
         state           <= state_next;
         clock_divided   <= clock_next;
         period_start    <= start_next;
         cfg_error       <= reject;
         pending         <= pending_next;
         pending_divisor <= pending_divisor_next;
         active_divisor  <= active_next;
      end
   end

endmodule
